// File: rtl/traffic_sink.sv
// Ejection-side packet consumer: accepts one packet at a time over rec_req/rec_ack,
// checks flit order, destination and body length, and keeps latency and saturating statistics.
module traffic_sink #(
  parameter int FLIT_SIZE  = 32,
  parameter int X_ADDR     = 0,
  parameter int Y_ADDR     = 0,
  parameter int BODY_COUNT = 2,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_rec_req,
  output logic                 o_rec_ack,
  input  logic [FLIT_SIZE-1:0] i_flit,
  output logic                 o_pkt_done,
  output logic                 o_err,
  output logic [2:0]           o_err_code,
  output logic [15:0]          o_last_latency,
  output logic [CNT_W-1:0]     o_pkt_count,
  output logic [CNT_W-1:0]     o_flit_count,
  output logic [CNT_W-1:0]     o_err_count,
  output logic [1:0]           o_dbg_state
);

  // Handshake: o_rec_ack is a decode of the registered state, so it is high exactly
  // while the sink owns the port; a flit is consumed on every rising edge with
  // o_rec_ack=1, and a flit with its valid bit clear is a bubble.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HEAD = 2'd1,
    BODY      = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  localparam logic [1:0] TY_HEAD = 2'd1;
  localparam logic [1:0] TY_BODY = 2'd2;
  localparam logic [1:0] TY_TAIL = 2'd3;

  localparam logic [2:0] ERR_SEQ     = 3'd1;
  localparam logic [2:0] ERR_DEST    = 3'd2;
  localparam logic [2:0] ERR_LEN     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam int          TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [7:0]  BC     = 8'(BODY_COUNT);
  localparam logic [3:0]  X_EXP  = 4'(X_ADDR);
  localparam logic [3:0]  Y_EXP  = 4'(Y_ADDR);

  state_t          state, state_d;
  logic [7:0]      bodycnt, bodycnt_d;
  logic [TW-1:0]   timer, timer_d;
  logic [15:0]     cycle_cnt;
  logic            err_fire;
  logic [2:0]      err_code_d;
  logic            accept;

  logic            f_valid;
  logic [1:0]      f_type;
  logic [3:0]      f_x;
  logic [3:0]      f_y;
  logic [15:0]     f_payload;
  logic            unused_flit_bits;

  assign f_valid   = i_flit[FLIT_SIZE-1];
  assign f_type    = i_flit[FLIT_SIZE-2 -: 2];
  assign f_x       = i_flit[FLIT_SIZE-4 -: 4];
  assign f_y       = i_flit[FLIT_SIZE-8 -: 4];
  assign f_payload = i_flit[15:0];
  assign unused_flit_bits = ^i_flit[FLIT_SIZE-12:16];

  assign o_rec_ack   = (state != IDLE);
  assign o_dbg_state = state;

  always_comb begin
    state_d    = state;
    bodycnt_d  = bodycnt;
    timer_d    = timer;
    err_fire   = 1'b0;
    err_code_d = 3'd0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (i_rec_req && i_enable) state_d = WAIT_HEAD;
      end
      default: begin
        if (!f_valid) begin
          // Bubbles age the packet; DRAIN gives up silently since its error is already reported.
          if (timer == TMAX) begin
            timer_d = '0;
            state_d = IDLE;
            if (state != DRAIN) begin
              err_fire   = 1'b1;
              err_code_d = ERR_TIMEOUT;
            end
          end else begin
            timer_d = timer + TW'(1);
          end
        end else begin
          timer_d = '0;
          case (state)
            WAIT_HEAD: begin
              if (f_type == TY_HEAD) begin
                if (f_x == X_EXP && f_y == Y_EXP) begin
                  state_d   = BODY;
                  bodycnt_d = 8'd0;
                end else begin
                  state_d    = DRAIN;
                  err_fire   = 1'b1;
                  err_code_d = ERR_DEST;
                end
              end else begin
                state_d    = DRAIN;
                err_fire   = 1'b1;
                err_code_d = ERR_SEQ;
              end
            end
            BODY: begin
              case (f_type)
                TY_BODY: begin
                  if (bodycnt == BC) begin
                    state_d    = DRAIN;
                    err_fire   = 1'b1;
                    err_code_d = ERR_LEN;
                  end else begin
                    bodycnt_d = bodycnt + 8'd1;
                  end
                end
                TY_TAIL: begin
                  state_d = IDLE;
                  if (bodycnt == BC) begin
                    accept = 1'b1;
                  end else begin
                    err_fire   = 1'b1;
                    err_code_d = ERR_LEN;
                  end
                end
                default: begin
                  state_d    = DRAIN;
                  err_fire   = 1'b1;
                  err_code_d = ERR_SEQ;
                end
              endcase
            end
            DRAIN: begin
              if (f_type == TY_TAIL) state_d = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bodycnt        <= 8'd0;
      timer          <= '0;
      cycle_cnt      <= 16'd0;
      o_pkt_done     <= 1'b0;
      o_err          <= 1'b0;
      o_err_code     <= 3'd0;
      o_last_latency <= 16'd0;
      o_pkt_count    <= '0;
      o_flit_count   <= '0;
      o_err_count    <= '0;
    end else begin
      state      <= state_d;
      bodycnt    <= bodycnt_d;
      timer      <= timer_d;
      cycle_cnt  <= cycle_cnt + 16'd1;
      o_pkt_done <= accept;
      o_err      <= err_fire;
      if (err_fire) begin
        o_err_code <= err_code_d;
        if (o_err_count != '1) o_err_count <= o_err_count + CNT_W'(1);
      end
      if (accept) begin
        o_last_latency <= cycle_cnt - f_payload;
        if (o_pkt_count != '1) o_pkt_count <= o_pkt_count + CNT_W'(1);
      end
      if (state != IDLE && f_valid && o_flit_count != '1)
        o_flit_count <= o_flit_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_traffic_sink.sv
// Directed bench for traffic_sink: good packets, each error code, timeouts, enable gating,
// back-to-back re-arm, latency wrap, mid-packet reset and counter saturation.
module tb_traffic_sink;

  logic        clk;
  logic        reset;
  logic        i_enable;
  logic        i_rec_req;
  logic [31:0] i_flit;
  logic        o_rec_ack;
  logic        o_pkt_done;
  logic        o_err;
  logic [2:0]  o_err_code;
  logic [15:0] o_last_latency;
  logic [15:0] o_pkt_count;
  logic [15:0] o_flit_count;
  logic [15:0] o_err_count;
  logic [1:0]  o_dbg_state;

  logic        sat_rec_ack;
  logic        sat_pkt_done;
  logic        sat_err;
  logic [2:0]  sat_err_code;
  logic [15:0] sat_last_latency;
  logic [1:0]  sat_pkt_count;
  logic [1:0]  sat_flit_count;
  logic [1:0]  sat_err_count;
  logic [1:0]  sat_dbg_state;

  logic [15:0] tb_cyc;
  int          n_checks;
  int          n_pass;

  traffic_sink dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_rec_req(i_rec_req),
    .o_rec_ack(o_rec_ack), .i_flit(i_flit), .o_pkt_done(o_pkt_done), .o_err(o_err),
    .o_err_code(o_err_code), .o_last_latency(o_last_latency), .o_pkt_count(o_pkt_count),
    .o_flit_count(o_flit_count), .o_err_count(o_err_count), .o_dbg_state(o_dbg_state)
  );

  // Narrow-counter copy on the same stimulus so saturation is reachable quickly.
  traffic_sink #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_rec_req(i_rec_req),
    .o_rec_ack(sat_rec_ack), .i_flit(i_flit), .o_pkt_done(sat_pkt_done), .o_err(sat_err),
    .o_err_code(sat_err_code), .o_last_latency(sat_last_latency), .o_pkt_count(sat_pkt_count),
    .o_flit_count(sat_flit_count), .o_err_count(sat_err_count), .o_dbg_state(sat_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= reset ? 16'd0 : tb_cyc + 16'd1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] x,
                                     input logic [3:0] y, input logic [15:0] p);
    return {1'b1, t, x, y, 5'b0, p};
  endfunction

  task automatic put(input logic [31:0] f);
    i_flit = f;
    tick();
    i_flit = 32'h0;
  endtask

  task automatic bubbles(input int n);
    i_flit = 32'h0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic open_port();
    i_rec_req = 1'b1;
    i_flit    = 32'h0;
    tick();
    i_rec_req = 1'b0;
  endtask

  task automatic good_pkt(input logic [15:0] lat);
    open_port();
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd3, 4'd0, 4'd0, tb_cyc - lat));
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1; i_enable = 1'b1; i_rec_req = 1'b0; i_flit = 32'h0;
    repeat (3) tick();
    n_checks++; if ({o_rec_ack, o_pkt_done, o_err, o_err_code, o_dbg_state} !== 8'h00)
      $display("FAIL reset_ctrl: got %0h expected 0", {o_rec_ack, o_pkt_done, o_err, o_err_code, o_dbg_state}); else n_pass++;
    n_checks++; if ({o_last_latency, o_pkt_count, o_flit_count, o_err_count} !== 64'h0)
      $display("FAIL reset_stats: got %0h expected 0", {o_last_latency, o_pkt_count, o_flit_count, o_err_count}); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_good_packet();
    open_port();
    n_checks++; if ({o_rec_ack, o_dbg_state} !== 3'b101)
      $display("FAIL good_arm: got %0h expected 5", {o_rec_ack, o_dbg_state}); else n_pass++;
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    n_checks++; if (o_pkt_done !== 1'b0)
      $display("FAIL good_early_done: got %0d expected 0", o_pkt_done); else n_pass++;
    put(mk(2'd3, 4'd0, 4'd0, tb_cyc - 16'd5));
    n_checks++; if ({o_pkt_done, o_rec_ack, o_err} !== 3'b100)
      $display("FAIL good_done_ack: got %0b expected 100", {o_pkt_done, o_rec_ack, o_err}); else n_pass++;
    n_checks++; if (o_last_latency !== 16'd5)
      $display("FAIL good_latency: got %0d expected 5", o_last_latency); else n_pass++;
    n_checks++; if ({o_pkt_count, o_flit_count} !== {16'd1, 16'd4})
      $display("FAIL good_counts: got pkt %0d flit %0d expected 1 4", o_pkt_count, o_flit_count); else n_pass++;
    tick();
    n_checks++; if (o_pkt_done !== 1'b0)
      $display("FAIL good_done_pulse: got %0d expected 0", o_pkt_done); else n_pass++;
  endtask

  task automatic test_wrong_dest();
    open_port();
    put(mk(2'd1, 4'd1, 4'd0, 16'h0));
    n_checks++; if ({o_err, o_err_code, o_dbg_state, o_rec_ack} !== {1'b1, 3'd2, 2'd3, 1'b1})
      $display("FAIL dest_err: got %0h expected %0h", {o_err, o_err_code, o_dbg_state, o_rec_ack}, {1'b1, 3'd2, 2'd3, 1'b1}); else n_pass++;
    n_checks++; if (o_err_count !== 16'd1)
      $display("FAIL dest_err_count: got %0d expected 1", o_err_count); else n_pass++;
    put(mk(2'd2, 4'd1, 4'd0, 16'h0));
    n_checks++; if ({o_err, o_rec_ack} !== 2'b01)
      $display("FAIL dest_drain: got %0b expected 01", {o_err, o_rec_ack}); else n_pass++;
    put(mk(2'd2, 4'd1, 4'd0, 16'h0));
    put(mk(2'd3, 4'd1, 4'd0, 16'h0));
    n_checks++; if ({o_rec_ack, o_dbg_state, o_pkt_done} !== 4'b0000)
      $display("FAIL dest_tail_exit: got %0b expected 0000", {o_rec_ack, o_dbg_state, o_pkt_done}); else n_pass++;
    n_checks++; if ({o_err_count, o_pkt_count, o_flit_count} !== {16'd1, 16'd1, 16'd8})
      $display("FAIL dest_counts: got err %0d pkt %0d flit %0d expected 1 1 8", o_err_count, o_pkt_count, o_flit_count); else n_pass++;
  endtask

  task automatic test_body_length();
    open_port();
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd3, 4'd0, 4'd0, 16'h0));
    n_checks++; if ({o_err, o_err_code, o_dbg_state, o_rec_ack, o_pkt_done} !== {1'b1, 3'd3, 2'd0, 1'b0, 1'b0})
      $display("FAIL short_body: got %0h expected %0h", {o_err, o_err_code, o_dbg_state, o_rec_ack, o_pkt_done}, {1'b1, 3'd3, 2'd0, 1'b0, 1'b0}); else n_pass++;
    open_port();
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    n_checks++; if (o_err !== 1'b0)
      $display("FAIL long_body_early: got %0d expected 0", o_err); else n_pass++;
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    n_checks++; if ({o_err, o_err_code, o_dbg_state} !== {1'b1, 3'd3, 2'd3})
      $display("FAIL long_body: got %0h expected %0h", {o_err, o_err_code, o_dbg_state}, {1'b1, 3'd3, 2'd3}); else n_pass++;
    put(mk(2'd3, 4'd0, 4'd0, 16'h0));
    n_checks++; if ({o_err_count, o_pkt_count, o_flit_count} !== {16'd3, 16'd1, 16'd16})
      $display("FAIL length_counts: got err %0d pkt %0d flit %0d expected 3 1 16", o_err_count, o_pkt_count, o_flit_count); else n_pass++;
  endtask

  task automatic test_timeout();
    open_port();
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    bubbles(63);
    n_checks++; if ({o_err, o_rec_ack, o_dbg_state} !== {1'b0, 1'b1, 2'd2})
      $display("FAIL timeout_63: got %0h expected %0h", {o_err, o_rec_ack, o_dbg_state}, {1'b0, 1'b1, 2'd2}); else n_pass++;
    bubbles(1);
    n_checks++; if ({o_err, o_err_code, o_rec_ack, o_dbg_state} !== {1'b1, 3'd4, 1'b0, 2'd0})
      $display("FAIL timeout_64: got %0h expected %0h", {o_err, o_err_code, o_rec_ack, o_dbg_state}, {1'b1, 3'd4, 1'b0, 2'd0}); else n_pass++;
    n_checks++; if ({o_err_count, o_flit_count} !== {16'd4, 16'd17})
      $display("FAIL timeout_counts: got err %0d flit %0d expected 4 17", o_err_count, o_flit_count); else n_pass++;
    // Valid flits restart the idle timer, so long gaps below the limit are fine.
    open_port();
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    bubbles(40);
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    bubbles(40);
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd3, 4'd0, 4'd0, tb_cyc - 16'd9));
    n_checks++; if ({o_pkt_done, o_pkt_count, o_err_count, o_last_latency} !== {1'b1, 16'd2, 16'd4, 16'd9})
      $display("FAIL timer_clear: got done %0d pkt %0d err %0d lat %0d expected 1 2 4 9", o_pkt_done, o_pkt_count, o_err_count, o_last_latency); else n_pass++;
    open_port();
    put(mk(2'd1, 4'd2, 4'd0, 16'h0));
    bubbles(63);
    n_checks++; if (o_dbg_state !== 2'd3)
      $display("FAIL drain_63: got %0d expected 3", o_dbg_state); else n_pass++;
    bubbles(1);
    n_checks++; if ({o_err, o_rec_ack, o_dbg_state, o_err_code} !== {1'b0, 1'b0, 2'd0, 3'd2})
      $display("FAIL drain_timeout: got %0h expected %0h", {o_err, o_rec_ack, o_dbg_state, o_err_code}, {1'b0, 1'b0, 2'd0, 3'd2}); else n_pass++;
    n_checks++; if ({o_err_count, o_flit_count} !== {16'd5, 16'd22})
      $display("FAIL drain_counts: got err %0d flit %0d expected 5 22", o_err_count, o_flit_count); else n_pass++;
  endtask

  task automatic test_enable();
    i_enable = 1'b0; i_rec_req = 1'b1;
    repeat (3) tick();
    n_checks++; if ({o_rec_ack, o_dbg_state} !== 3'b000)
      $display("FAIL enable_block: got %0h expected 0", {o_rec_ack, o_dbg_state}); else n_pass++;
    i_enable = 1'b1;
    tick();
    i_rec_req = 1'b0; i_enable = 1'b0;
    n_checks++; if (o_rec_ack !== 1'b1)
      $display("FAIL enable_arm: got %0d expected 1", o_rec_ack); else n_pass++;
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd3, 4'd0, 4'd0, tb_cyc - 16'd7));
    n_checks++; if ({o_pkt_done, o_pkt_count, o_flit_count, o_last_latency} !== {1'b1, 16'd3, 16'd26, 16'd7})
      $display("FAIL enable_midpkt: got done %0d pkt %0d flit %0d lat %0d expected 1 3 26 7", o_pkt_done, o_pkt_count, o_flit_count, o_last_latency); else n_pass++;
    i_enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    i_rec_req = 1'b1;
    tick();
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd3, 4'd0, 4'd0, tb_cyc - 16'd3));
    n_checks++; if ({o_pkt_done, o_rec_ack} !== 2'b10)
      $display("FAIL b2b_gap: got %0b expected 10", {o_pkt_done, o_rec_ack}); else n_pass++;
    tick();
    n_checks++; if ({o_pkt_done, o_rec_ack} !== 2'b01)
      $display("FAIL b2b_rearm: got %0b expected 01", {o_pkt_done, o_rec_ack}); else n_pass++;
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    i_rec_req = 1'b0;
    put(mk(2'd3, 4'd0, 4'd0, tb_cyc - 16'd11));
    n_checks++; if ({o_pkt_count, o_flit_count, o_last_latency} !== {16'd5, 16'd34, 16'd11})
      $display("FAIL b2b_counts: got pkt %0d flit %0d lat %0d expected 5 34 11", o_pkt_count, o_flit_count, o_last_latency); else n_pass++;
  endtask

  task automatic test_latency_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // Tail lands on cycle_cnt 4 after reset; 4 - 0xFFFE wraps to 6.
    open_port();
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    put(mk(2'd3, 4'd0, 4'd0, 16'hFFFE));
    n_checks++; if ({o_pkt_done, o_last_latency, o_pkt_count} !== {1'b1, 16'd6, 16'd1})
      $display("FAIL latency_wrap: got done %0d lat %0h pkt %0d expected 1 6 1", o_pkt_done, o_last_latency, o_pkt_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    open_port();
    put(mk(2'd1, 4'd0, 4'd0, 16'h0));
    put(mk(2'd2, 4'd0, 4'd0, 16'h0));
    reset = 1'b1;
    tick();
    n_checks++; if ({o_rec_ack, o_pkt_done, o_err, o_err_code, o_dbg_state} !== 8'h00)
      $display("FAIL reset_mid_ctrl: got %0h expected 0", {o_rec_ack, o_pkt_done, o_err, o_err_code, o_dbg_state}); else n_pass++;
    n_checks++; if ({o_last_latency, o_pkt_count, o_flit_count, o_err_count} !== 64'h0)
      $display("FAIL reset_mid_stats: got %0h expected 0", {o_last_latency, o_pkt_count, o_flit_count, o_err_count}); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) good_pkt(16'd5);
    n_checks++; if ({sat_pkt_count, sat_flit_count, sat_pkt_done} !== {2'd3, 2'd3, 1'b1})
      $display("FAIL sat_counts: got pkt %0d flit %0d done %0d expected 3 3 1", sat_pkt_count, sat_flit_count, sat_pkt_done); else n_pass++;
    n_checks++; if ({o_pkt_count, o_flit_count} !== {16'd4, 16'd16})
      $display("FAIL sat_wide_counts: got pkt %0d flit %0d expected 4 16", o_pkt_count, o_flit_count); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_good_packet();
    test_wrong_dest();
    test_body_length();
    test_timeout();
    test_enable();
    test_back_to_back();
    test_latency_wrap();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
